mem_arbiter: RTL
================

# mem_arbiter

Shares a single external memory bus between the instruction-fetch port and the memory-access stage of the pipeline. It sequences at most one bus transaction at a time, with data priority, and raises a pipeline stall until every active requester has been served in the current pipeline step. It sits between the pipeline (fetch stage and `mem` stage outputs) and the memory/bus interface, and it aborts hung transactions with a watchdog.

## Interface
- `TIMEOUT`, default 255: the maximum number of cycles the block waits for `bus_ack_i` before aborting. The legal range is 1 to 65535.
- `clk` in 1: the single clock. All registers update on the rising edge.
- `rst` in 1: reset. Asynchronous and active-low.
- `if_ce_i` in 1: instruction-fetch request.
- `if_addr_i` in 32: fetch address.
- `if_data_o` out 32: fetched instruction (registered).
- `dm_ce_i` in 1: data request from the memory stage.
- `dm_we_i` in 1: 1 selects a write, 0 selects a read.
- `dm_sel_i` in 4: byte-lane select for the data request.
- `dm_addr_i` in 32: data address.
- `dm_data_i` in 32: write data.
- `dm_data_o` out 32: read data (registered).
- `stall_req_o` out 1: stall request to pipeline control.
- `bus_req_o` out 1: bus request (registered).
- `bus_we_o` out 1: bus write enable (registered).
- `bus_sel_o` out 4: bus byte-lane select (registered).
- `bus_addr_o` out 32: bus address (registered).
- `bus_wdata_o` out 32: bus write data (registered).
- `bus_rdata_i` in 32: bus read data. Valid in the cycle `bus_ack_i` is high.
- `bus_ack_i` in 1: transaction complete.
- `bus_err_o` out 1: one-cycle pulse on watchdog abort (registered).

## Operation
- **States:**
  - IDLE: no transaction on the bus.
  - DBUS: data transaction in progress.
  - IBUS: instruction transaction in progress.
- **Sticky flags:** `dm_done` and `if_done` record which requesters have been served in the current pipeline step.
- **`stall_req_o`** is combinational: `(dm_ce_i & ~dm_done) | (if_ce_i & ~if_done)`. It is forced to 0 while `rst` is low.
- **Pipeline advance:** the pipeline advances at any edge where `stall_req_o` is 0. At that edge both done flags clear.
- **IDLE arbitration:**
  - If `dm_ce_i & ~dm_done`: latch `dm_we_i`, `dm_sel_i`, `dm_addr_i` and `dm_data_i` onto the bus outputs, set `bus_req_o` to 1, and go to DBUS.
  - Else if `if_ce_i & ~if_done`: drive `bus_we_o`=0, `bus_sel_o`=4'b1111 and `bus_addr_o`=`if_addr_i`, set `bus_req_o` to 1, and go to IBUS.
  - Else stay in IDLE with `bus_req_o` at 0.
- **Service order:** data is always served before instruction within a step. Each requester is served at most once per step, so neither requester can starve.
- **DBUS or IBUS, `bus_ack_i` sampled high:**
  - Clear `bus_req_o`.
  - Set the matching done flag.
  - On a read, capture `bus_rdata_i` into `dm_data_o` or `if_data_o`. A data write leaves `dm_data_o` unchanged.
  - Return to IDLE. There is no direct DBUS→IBUS transition.
- **Watchdog:**
  - A 16-bit counter clears on entry to DBUS/IBUS and increments each cycle without an ack.
  - When it equals `TIMEOUT` with no ack, abort:
    - clear `bus_req_o`;
    - pulse `bus_err_o` for one cycle;
    - set the done flag;
    - load 0 into the requester's data output (reads only);
    - return to IDLE.
  - An ack in the same cycle as the timeout takes precedence and is treated as normal completion.
- **Bus qualifiers:** `bus_we_o`, `bus_sel_o`, `bus_addr_o` and `bus_wdata_o` hold their latched values from grant through ack. They are not updated in IDLE unless a new grant occurs.
- **Requester rules:** requesters must hold their inputs stable while `stall_req_o` is 1. Input changes during a transaction do not affect the bus.
- **Stray ack:** `bus_ack_i` sampled in IDLE is ignored.
- **Dropped request:** if a requester drops its `ce` mid-transaction, the transaction still completes and the done flag is still set.

## Timing
- **Reset values:** with `rst` low, asynchronously:
  - state = IDLE;
  - `bus_req_o`, `bus_we_o`, `bus_err_o` = 0;
  - `bus_sel_o` = 4'b0000;
  - `bus_addr_o`, `bus_wdata_o`, `if_data_o`, `dm_data_o` = 0;
  - done flags and watchdog counter = 0.
- **Reset mid-transaction:** `bus_req_o` drops immediately. No done flag is set and no error is raised.
- **Zero-wait single request:**
  - Cycle 0: IDLE sees the request; `stall_req_o`=1.
  - Cycle 1: `bus_req_o`=1 and `bus_ack_i`=1.
  - Cycle 2: data output is valid and `stall_req_o`=0.
  - The stall lasts 2 cycles.
- **Both requests, zero-wait:** DBUS occupies cycles 1, IBUS occupies cycle 3, and `stall_req_o` falls in cycle 4.
- **Wait states:** each wait-state cycle without `bus_ack_i` adds one cycle of latency.
- **Abort timing:** on abort, `bus_req_o` was high for exactly `TIMEOUT`+1 cycles. `bus_err_o` is high in the cycle after the abort edge.

## Test plan
- **Reset:** assert `rst`=0 mid-DBUS → `bus_req_o` drops the same cycle, all outputs return to their reset values, and `stall_req_o`=0.
- **Zero-wait data read:** `dm_ce_i`=1, `dm_we_i`=0, `dm_addr_i`=0x100; memory acks in cycle 1 with 0xDEADBEEF → `bus_sel_o`=`dm_sel_i`, `dm_data_o`=0xDEADBEEF in cycle 2, and `stall_req_o` is 1,1,0 over cycles 0-2.
- **Simultaneous requests:** `if_ce_i`=1 with `if_addr_i`=0x0, plus a data write `dm_sel_i`=4'b0001, `dm_data_i`=0x000000AB, 3 wait states each → the write is issued first with `bus_wdata_o`=0xAB, then a fetch with `bus_sel_o`=4'b1111. `stall_req_o` drops only after both complete, 10 cycles after the first request, and `dm_data_o` is unchanged.
- **Back-to-back steps:** 20 consecutive load+fetch steps → each step yields exactly one DBUS and one IBUS grant, in data-then-instruction order.
- **Watchdog:** `TIMEOUT`=4 and ack never arrives on an instruction fetch → `bus_req_o` is high for 5 cycles, `bus_err_o` pulses once, `if_data_o`=0 and `stall_req_o` then falls. Repeat with ack in the timeout cycle → normal completion and no error.
- **Stray ack:** `bus_ack_i` pulsed while in IDLE → no state change and no data capture.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory bus between fetch and data ports, data first, with a watchdog
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        dm_ce_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_i,
  output logic [31:0] dm_data_o,
  output logic        stall_req_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DBUS = 2'd1,
    ST_IBUS = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_dm_done;
  logic        r_if_done;
  logic [15:0] r_wdog;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_bus_err;
  logic [31:0] r_dm_data;
  logic [31:0] r_if_data;

  logic w_dm_pend;
  logic w_if_pend;
  logic w_stall;
  logic w_grant_d;
  logic w_grant_i;
  logic w_ack;
  logic w_abort;
  logic w_end_d;
  logic w_end_i;

  assign w_dm_pend = dm_ce_i & ~r_dm_done;
  assign w_if_pend = if_ce_i & ~r_if_done;
  // Stall is held low while in reset so the pipeline is not frozen by a stale request.
  assign w_stall   = rst & (w_dm_pend | w_if_pend);

  assign w_end_d = (w_ack | w_abort) & (r_state == ST_DBUS);
  assign w_end_i = (w_ack | w_abort) & (r_state == ST_IBUS);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode: data wins arbitration; an ack beats a simultaneous timeout.
  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_ack        = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dm_pend) begin
          w_grant_d    = 1'b1;
          w_next_state = ST_DBUS;
        end else if (w_if_pend) begin
          w_grant_i    = 1'b1;
          w_next_state = ST_IBUS;
        end
      end
      ST_DBUS, ST_IBUS: begin
        if (bus_ack_i) begin
          w_ack        = 1'b1;
          w_next_state = ST_IDLE;
        end else if (r_wdog == LP_TIMEOUT) begin
          w_abort      = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Bus request and qualifiers: latched on grant, held until the transaction ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'b0000;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
    end else begin
      if (w_grant_d) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= dm_we_i;
        r_bus_sel   <= dm_sel_i;
        r_bus_addr  <= dm_addr_i;
        r_bus_wdata <= dm_data_i;
      end else if (w_grant_i) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= 1'b0;
        r_bus_sel   <= 4'b1111;
        r_bus_addr  <= if_addr_i;
      end else if (w_ack || w_abort) begin
        r_bus_req   <= 1'b0;
      end
    end
  end

  // Done flags: cleared when the pipeline advances, set when a transaction ends (set wins).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dm_done <= 1'b0;
      r_if_done <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_dm_done <= 1'b0;
        r_if_done <= 1'b0;
      end
      if (w_end_d) r_dm_done <= 1'b1;
      if (w_end_i) r_if_done <= 1'b1;
    end
  end

  // Watchdog: restarts on every grant, counts cycles spent waiting for an ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= 16'h0;
    end else if (w_grant_d || w_grant_i) begin
      r_wdog <= 16'h0;
    end else if ((r_state != ST_IDLE) && !w_ack && !w_abort) begin
      r_wdog <= r_wdog + 16'h1;
    end
  end

  // Read data capture; an aborted read returns zero, writes leave the data output alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dm_data <= 32'h0;
      r_if_data <= 32'h0;
    end else begin
      if (w_end_d && !r_bus_we) r_dm_data <= w_ack ? bus_rdata_i : 32'h0;
      if (w_end_i)              r_if_data <= w_ack ? bus_rdata_i : 32'h0;
    end
  end

  // Error pulse, one cycle after an abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_bus_err <= 1'b0;
    else      r_bus_err <= w_abort;
  end

  assign stall_req_o = w_stall;
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_sel_o   = r_bus_sel;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_err_o   = r_bus_err;
  assign dm_data_o   = r_dm_data;
  assign if_data_o   = r_if_data;

endmodule
